// File: rtl/data_memory_pkg.sv
// Shared types, limits and address-check helpers for the data memory controller.
package data_memory_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Supported range of cycles spent in ACCESS
  localparam int unsigned READ_LATENCY_MIN = 32'd1;
  localparam int unsigned READ_LATENCY_MAX = 32'd4;

  // Force a latency parameter into the supported range
  function automatic int unsigned clamp_latency(input int unsigned lat);
    int unsigned res;
    if (lat < READ_LATENCY_MIN) begin
      res = READ_LATENCY_MIN;
    end else if (lat > READ_LATENCY_MAX) begin
      res = READ_LATENCY_MAX;
    end else begin
      res = lat;
    end
    return res;
  endfunction

  // Any byte-offset bit set below the word boundary
  function automatic logic addr_misaligned(input logic [31:0] addr, input int unsigned off_bits);
    logic [31:0] mask;
    mask = (32'd1 << off_bits) - 32'd1;
    return |(addr & mask);
  endfunction

  // Any bit set above the byte-offset plus word-index field
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned used_bits);
    logic res;
    if (used_bits >= 32'd32) begin
      res = 1'b0;
    end else begin
      res = |(addr >> used_bits);
    end
    return res;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a requester and the data memory controller.
interface data_memory_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [31:0]             req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_array.sv
// Word storage with byte-lane writes and a registered read port; no reset on contents.
module data_memory_array #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata
);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Byte-lane write: only lanes with their strobe set are updated
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wstrb[i]) begin
          mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read capture: load a new word on a read, otherwise hold the last one
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem_q[addr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-outstanding request controller in front of a byte-enable word memory.
// Requests are checked for alignment and range at acceptance; legal writes
// commit at the acceptance edge, reads are captured then and presented after
// READ_LATENCY cycles in ACCESS.
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic               CLK,
  input  logic               reset,
  data_memory_ctrl_if.slave  bus
);
  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS  = $clog2(NUM_LANES);
  localparam int unsigned USED_BITS = ADDR_WIDTH + OFF_BITS;
  localparam int unsigned LAT       = clamp_latency(READ_LATENCY);
  localparam logic [1:0]  CNT_LAST  = 2'(LAT - 32'd1);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_error_q, resp_error_d;

  logic                  accept_s;
  logic                  req_err_s;
  logic                  arr_wr_s;
  logic                  arr_rd_s;
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [DATA_WIDTH-1:0] arr_rdata_s;

  assign accept_s   = (state_q == ST_IDLE) && bus.req_valid;
  assign req_err_s  = addr_misaligned(bus.req_addr, OFF_BITS) |
                      addr_out_of_range(bus.req_addr, USED_BITS);
  assign word_idx_s = bus.req_addr[OFF_BITS +: ADDR_WIDTH];

  // A rejected request never touches the array
  assign arr_wr_s = accept_s && bus.req_write && !req_err_s;
  assign arr_rd_s = accept_s && !bus.req_write && !req_err_s;

  data_memory_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (CLK),
    .wr_en (arr_wr_s),
    .rd_en (arr_rd_s),
    .addr  (word_idx_s),
    .wdata (bus.req_wdata),
    .wstrb (bus.req_wstrb),
    .rdata (arr_rdata_s)
  );

  // Next-state and response computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    wr_d         = wr_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d = ST_ACCESS;
          cnt_d   = 2'd0;
          err_d   = req_err_s;
          wr_d    = bus.req_write;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d      = ST_RESP;
          cnt_d        = 2'd0;
          resp_error_d = err_q;
          if (err_q || wr_q) begin
            resp_rdata_d = {DATA_WIDTH{1'b0}};
          end else begin
            resp_rdata_d = arr_rdata_s;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_rdata_d = {DATA_WIDTH{1'b0}};
          resp_error_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cnt_d        = 2'd0;
        resp_rdata_d = {DATA_WIDTH{1'b0}};
        resp_error_d = 1'b0;
      end
    endcase
  end

  // State, counter and response registers; reset drops any pending response
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      err_q        <= 1'b0;
      wr_q         <= 1'b0;
      resp_rdata_q <= {DATA_WIDTH{1'b0}};
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      wr_q         <= wr_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl with READ_LATENCY=3, 32-bit words, 256 words.
module tb_data_memory_ctrl;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic CLK;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  data_memory_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  data_memory_ctrl #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (LAT)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle counter used to measure request spacing
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request: accept, wait for the response, optionally stall, then consume
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] exp_rd, input logic exp_er, input int stall);
    int lat;
    @(negedge CLK);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_wstrb  = ws;
    bus.resp_ready = 1'b0;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_wstrb = 4'hF;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_rdata"}, 64'(bus.resp_rdata), 64'(exp_rd));
    check({tag, "_error"}, 64'(bus.resp_error), 64'(exp_er));
    for (int i = 0; i < stall; i++) begin
      @(negedge CLK);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = addr;
      bus.req_wdata = 32'h0000_0000;
      bus.req_wstrb = 4'hF;
      check({tag, "_stall_rdata"}, 64'(bus.resp_rdata), 64'(exp_rd));
      check({tag, "_stall_error"}, 64'(bus.resp_error), 64'(exp_er));
      check({tag, "_stall_req_ready"}, 64'(bus.req_ready), 64'd0);
      check({tag, "_stall_resp_valid"}, 64'(bus.resp_valid), 64'd1);
    end
    @(negedge CLK);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.resp_ready = 1'b0;
    check({tag, "_consumed"}, 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    int acc [2];
    int n_acc;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_wstrb  = 4'h0;
    bus.resp_ready = 1'b0;
    acc[0] = 0;
    acc[1] = 0;
    n_acc  = 0;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_rdata", 64'(bus.resp_rdata), 64'd0);
    check("rst_error", 64'(bus.resp_error), 64'd0);
    @(negedge CLK);
    reset = 1'b0;

    // Full write then read back, then a single-lane update
    do_req("wr10",     1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
    do_req("rd10",     1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
    do_req("wr10_b0",  1'b1, 32'h10, 32'h0000_00AA, 4'h1, 32'h0, 1'b0, 0);
    do_req("rd10_b0",  1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 0);

    // Rejected requests: misaligned and out of range; aliasing word 0 must stay intact
    do_req("rd12_mis", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    do_req("wr00",     1'b1, 32'h0, 32'h0102_0304, 4'hF, 32'h0, 1'b0, 0);
    do_req("wr400",    1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
    do_req("rd400",    1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    do_req("rd00",     1'b0, 32'h0, 32'h0, 4'h0, 32'h0102_0304, 1'b0, 0);
    do_req("rd_hi",    1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    do_req("wr11_mis", 1'b1, 32'h11, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
    do_req("wr10_s0",  1'b1, 32'h10, 32'h1234_5678, 4'h0, 32'h0, 1'b0, 0);
    do_req("rd10_chk", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 0);

    // Stalled response: data held, new requests ignored
    do_req("wr30",      1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 0);
    do_req("rd30_stall",1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 5);
    do_req("rd30",      1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0);
    do_req("wr30_mix",  1'b1, 32'h30, 32'h1122_3344, 4'hA, 32'h0, 1'b0, 0);
    do_req("rd30_mix",  1'b0, 32'h30, 32'h0, 4'h0, 32'h11FE_330D, 1'b0, 0);

    // Reset while in ACCESS after a committed write
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h1234_5678;
    bus.req_wstrb = 4'hF;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    check("acc_req_ready", 64'(bus.req_ready), 64'd0);
    reset = 1'b1;
    #1;
    check("rst_acc_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_acc_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge CLK);
    reset = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("rst_no_resp", 64'(bus.resp_valid), 64'd0);
    do_req("rd20_after_rst", 1'b0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0);

    // Back-to-back reads with resp_ready high: one acceptance every LAT+2 cycles
    @(negedge CLK);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h10;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge CLK);
      if (bus.req_ready === 1'b1 && n_acc < 2) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      if (bus.resp_valid === 1'b1) begin
        check("thru_rdata", 64'(bus.resp_rdata), 64'hDEAD_BEAA);
      end
    end
    bus.req_valid = 1'b0;
    check("thru_n_acc", 64'(n_acc), 64'd2);
    check("thru_gap", 64'(acc[1] - acc[0]), 64'(LAT + 2));
    repeat (8) @(posedge CLK);
    #1;
    check("thru_drained", 64'(bus.req_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, word-index width; depth = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values are 32 and 64.
REQ-003 SHALL have parameter READ_LATENCY, default 1, cycles spent in ACCESS; legal range 1..4.
REQ-004 SHALL have port CLK, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted when high with req_valid at a CLK edge.
REQ-008 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, DATA_WIDTH, write data.
REQ-011 SHALL have port req_wstrb, input, DATA_WIDTH/8, byte-lane write enables.
REQ-012 SHALL have port resp_valid, output, 1, response present.
REQ-013 SHALL have port resp_ready, input, 1, response consumed when high with resp_valid at a CLK edge.
REQ-014 SHALL have port resp_rdata, output, DATA_WIDTH, read data.
REQ-015 SHALL have port resp_error, output, 1, request rejected.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready = (state==IDLE); resp_valid = (state==RESP).
REQ-017 SHALL take IDLE->ACCESS on acceptance, ACCESS->RESP after exactly READ_LATENCY cycles in ACCESS, RESP->IDLE on resp_valid&&resp_ready.
REQ-018 SHALL keep one request outstanding; req_* ignored outside IDLE.
REQ-019 SHALL flag misaligned: req_addr low log2(DATA_WIDTH/8) bits nonzero.
REQ-020 SHALL flag out-of-range: any req_addr bit above the word-index field nonzero.
REQ-021 SHALL on error perform no array access and respond resp_error=1, resp_rdata=0.
REQ-022 SHALL commit a legal write at the acceptance edge, updating only lanes with req_wstrb bit set; wstrb=0 is a legal no-op write.
REQ-023 SHALL respond to writes with resp_rdata=0, resp_error=0 (unless flagged).
REQ-024 SHALL respond to legal reads with the word as it stands after all previously accepted writes.
REQ-025 SHALL hold resp_rdata and resp_error stable throughout RESP until consumed.
REQ-026 SHALL, with resp_ready held high, sustain one request per READ_LATENCY+2 cycles.

Reset
REQ-027 SHALL on reset force state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, latency counter=0.
REQ-028 SHALL not clear array contents on reset; contents are undefined after power-up.
REQ-029 SHALL on reset mid-operation discard the pending response; a write committed before reset remains in the array.

Structure
REQ-030 SHALL place the state enum and the READ_LATENCY range limits in data_memory_pkg.
REQ-031 SHALL instantiate one sub-module data_memory_array: ADDR_WIDTH x DATA_WIDTH storage, byte-enable write, registered read, no reset on storage.

Verification
REQ-032 SHALL cover: write 0x0000_0010 data 0xDEADBEEF wstrb 0xF, then read 0x10 -> resp_rdata 0xDEADBEEF, resp_error 0.
REQ-033 SHALL cover: then write 0x10 data 0x0000_00AA wstrb 0x1, read 0x10 -> 0xDEADBEAA.
REQ-034 SHALL cover: read 0x0000_0012 -> resp_error 1, rdata 0; read 0x0000_0400 (ADDR_WIDTH=8) -> resp_error 1, no array change.
REQ-035 SHALL cover: READ_LATENCY=3, accept at edge k -> resp_valid high after edge k+3; resp_ready low 5 cycles -> rdata stable, req_ready low.
REQ-036 SHALL cover: assert reset in ACCESS after write 0x20 data 0x12345678 -> resp_valid 0 immediately; subsequent read 0x20 -> 0x12345678.
